// File: rtl/fifo_banked_pkg.sv
// rtl/fifo_banked_pkg.sv - shared widths, default thresholds and pointer split helpers for fifo_banked
//
// Purpose : derived-width functions, default flag thresholds and the
//           bank/address decomposition of a flat FIFO pointer.
// Ports   : none (package).
package fifo_banked_pkg;

    localparam int DEFAULT_AEMPTY_THRESH = 16;
    // almost_full default sits this many words below the total capacity
    localparam int DEFAULT_AFULL_MARGIN  = 16;

    function automatic int ptr_w(input int total);
        return $clog2(total);
    endfunction

    function automatic int cnt_w(input int total);
        return $clog2(total) + 1;
    endfunction

    // A single bank still needs a 1-bit select so the read mux stays legal.
    function automatic int bank_sel_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    // Upper pointer bits select the bank, lower addr_w bits address inside it.
    function automatic int unsigned ptr_bank(input int unsigned ptr, input int addr_w);
        return ptr >> addr_w;
    endfunction

    function automatic int unsigned ptr_addr(input int unsigned ptr, input int addr_w);
        return ptr & ((32'd1 << addr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_bank_ram.sv
// rtl/fifo_bank_ram.sv - one bank of simple dual-port RAM with a registered read port
//
// Purpose : DATA_WIDTH x DEPTH storage, one write port and one registered read port.
// Ports   : clk, rst (async active-low, clears only the read register),
//           we/waddr/wdata write port, re/raddr read request, rdata registered read data.
module fifo_bank_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2048
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value until the next read of this bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_banked.sv
// rtl/fifo_banked.sv - single logical FIFO striped across NUM_BANKS equal RAM banks
//
// Purpose : pointers, total and per-bank occupancy, status flags, sticky errors
//           and the registered read path over NUM_BANKS fifo_bank_ram instances.
// Ports   : clk, rst (async active-low); wr/data_in write side; rd read request;
//           data_out/data_valid registered read result; empty/full/almost_empty/
//           almost_full/count aggregate status; bank_empty/bank_full per bank;
//           overflow/underflow sticky errors cleared by clr_err.
module fifo_banked
    import fifo_banked_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int BANK_DEPTH    = 2048,
    parameter int NUM_BANKS     = 2,
    parameter int AFULL_THRESH  = NUM_BANKS * BANK_DEPTH - DEFAULT_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       wr,
    input  logic [DATA_WIDTH-1:0]                      data_in,
    input  logic                                       rd,
    output logic [DATA_WIDTH-1:0]                      data_out,
    output logic                                       data_valid,
    output logic                                       empty,
    output logic                                       full,
    output logic                                       almost_empty,
    output logic                                       almost_full,
    output logic [NUM_BANKS-1:0]                       bank_empty,
    output logic [NUM_BANKS-1:0]                       bank_full,
    output logic [cnt_w(NUM_BANKS*BANK_DEPTH)-1:0]     count,
    output logic                                       overflow,
    output logic                                       underflow,
    input  logic                                       clr_err
);

    localparam int TOTAL  = NUM_BANKS * BANK_DEPTH;
    localparam int PTR_W  = ptr_w(TOTAL);
    localparam int CNT_W  = cnt_w(TOTAL);
    localparam int ADDR_W = $clog2(BANK_DEPTH);
    localparam int BSEL_W = bank_sel_w(NUM_BANKS);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [BSEL_W-1:0]     wr_bank;
    logic [BSEL_W-1:0]     rd_bank;
    logic [BSEL_W-1:0]     rd_bank_q;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    assign wr_bank = BSEL_W'(ptr_bank(32'(wr_ptr), ADDR_W));
    assign rd_bank = BSEL_W'(ptr_bank(32'(rd_ptr), ADDR_W));
    assign wr_addr = ADDR_W'(ptr_addr(32'(wr_ptr), ADDR_W));
    assign rd_addr = ADDR_W'(ptr_addr(32'(rd_ptr), ADDR_W));

    // Flags come from the registered count, so both accepts see pre-edge state:
    // no fall-through on empty, no write-through on full.
    assign empty        = (count == '0);
    assign full         = (count == CNT_W'(TOTAL));
    assign almost_empty = (count <= CNT_W'(AEMPTY_THRESH));
    assign almost_full  = (count >= CNT_W'(AFULL_THRESH));

    assign wr_acc = wr && !full;
    assign rd_acc = rd && !empty;

    // Each bank's read register only moves when that bank is read, so muxing
    // by the bank of the last accepted read holds data_out between reads.
    assign data_out = bank_rdata[rd_bank_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_bank_q  <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                rd_bank_q <= rd_bank;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            data_valid <= rd_acc;
            // A fresh error wins over a same-cycle clear.
            overflow   <= (wr && full)  || (overflow  && !clr_err);
            underflow  <= (rd && empty) || (underflow && !clr_err);
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic              bank_we;
        logic              bank_re;
        logic [ADDR_W:0]   bank_cnt;

        assign bank_we = wr_acc && (wr_bank == BSEL_W'(g));
        assign bank_re = rd_acc && (rd_bank == BSEL_W'(g));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                bank_cnt <= '0;
            end else begin
                case ({bank_we, bank_re})
                    2'b10:   bank_cnt <= bank_cnt + (ADDR_W+1)'(1);
                    2'b01:   bank_cnt <= bank_cnt - (ADDR_W+1)'(1);
                    default: bank_cnt <= bank_cnt;
                endcase
            end
        end

        assign bank_empty[g] = (bank_cnt == '0);
        assign bank_full[g]  = (bank_cnt == (ADDR_W+1)'(BANK_DEPTH));

        fifo_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BANK_DEPTH)
        ) u_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we),
            .waddr (wr_addr),
            .wdata (data_in),
            .re    (bank_re),
            .raddr (rd_addr),
            .rdata (bank_rdata[g])
        );
    end

endmodule

// File: tb/tb_fifo_banked.sv
// tb/tb_fifo_banked.sv - scoreboard bench for fifo_banked against a queue reference model
module tb_fifo_banked;

    localparam int DW    = 16;
    localparam int BD    = 2048;
    localparam int NB    = 2;
    localparam int TOTAL = NB * BD;
    localparam int AF    = TOTAL - 16;
    localparam int AE    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr;
    logic          rd;
    logic          clr_err;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [NB-1:0] bank_empty;
    logic [NB-1:0] bank_full;
    logic [12:0]   count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    fifo_banked #(
        .DATA_WIDTH    (DW),
        .BANK_DEPTH    (BD),
        .NUM_BANKS     (NB),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .bank_empty   (bank_empty),
        .bank_full    (bank_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    // Reference model: logical FIFO contents, per-bank word counts derived from
    // the absolute position of each word, and the sticky error flags.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    int            mb[NB];
    int            wr_total;
    int            rd_total;
    bit            m_ovf;
    bit            m_udf;
    bit            m_valid;
    logic [DW-1:0] last_out;
    logic [DW-1:0] mon_e;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        foreach (mb[b]) mb[b] = 0;
        wr_total = 0;
        rd_total = 0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_valid  = 1'b0;
        last_out = '0;
    endtask

    task automatic check_state();
        int n;
        logic [NB-1:0] be;
        logic [NB-1:0] bf;
        n = mq.size();
        for (int b = 0; b < NB; b++) begin
            be[b] = (mb[b] == 0);
            bf[b] = (mb[b] == BD);
        end
        chk("count",        count,        n);
        chk("empty",        empty,        n == 0);
        chk("full",         full,         n == TOTAL);
        chk("almost_empty", almost_empty, n <= AE);
        chk("almost_full",  almost_full,  n >= AF);
        chk("bank_empty",   bank_empty,   be);
        chk("bank_full",    bank_full,    bf);
        chk("overflow",     overflow,     m_ovf);
        chk("underflow",    underflow,    m_udf);
        chk("data_valid",   data_valid,   m_valid);
    endtask

    // Called at a falling edge: drive, advance the model, take one clock, check.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
        bit f;
        bit e;
        f = (mq.size() == TOTAL);
        e = (mq.size() == 0);
        wr = w; rd = r; data_in = d; clr_err = c;
        m_valid = r && !e;
        if (m_valid) begin
            exp_q.push_back(mq.pop_front());
            mb[(rd_total % TOTAL) / BD]--;
            rd_total++;
        end
        if (w && !f) begin
            mq.push_back(d);
            mb[(wr_total % TOTAL) / BD]++;
            wr_total++;
        end
        m_ovf = (w && f) ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_udf = (r && e) ? 1'b1 : (c ? 1'b0 : m_udf);
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic write_n(input int n, input bit rnd);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, rnd ? DW'($urandom) : DW'(i), 1'b0);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, 1'b0);
    endtask

    // Asynchronous pulse well clear of both clock edges; outputs checked while low.
    task automatic async_reset_pulse();
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        m_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_state();
        chk("data_out_reset", data_out, 0);
        #4 rst = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every presented result is matched against the scoreboard;
    // without a strobe data_out must hold the last delivered word.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_data_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data_out", data_out, mon_e);
                    last_out = mon_e;
                end
            end else begin
                chk("data_out_hold", data_out, last_out);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_state();
        chk("data_out_reset", data_out, 0);
        rst = 1'b1;
        @(negedge clk);
        check_state();

        // Fill then overflow and full-with-read-and-write corner cases.
        write_n(TOTAL, 1'b0);
        step(1'b1, 1'b0, 16'hDEAD, 1'b0);
        step(1'b1, 1'b1, 16'hBEEF, 1'b0);
        step(1'b1, 1'b0, 16'h0FFF, 1'b0);
        step(1'b1, 1'b0, 16'h1234, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Drain, then underflow and empty-with-read-and-write corner cases.
        read_n(TOTAL);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 16'hA5A5, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        read_n(1);

        // Sustained simultaneous traffic at count 100.
        write_n(100, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b1, DW'($urandom), 1'b0);
        read_n(100);

        // Asynchronous reset mid-operation.
        write_n(1234, 1'b1);
        async_reset_pulse();
        step(1'b1, 1'b0, 16'h5EED, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Wrap from bank 1 back into bank 0, from a clean pointer origin.
        async_reset_pulse();
        write_n(3000, 1'b1);
        read_n(3000);
        write_n(2000, 1'b1);
        read_n(2000);

        // Randomised traffic: fill-biased then drain-biased.
        for (int i = 0; i < 3000; i++) begin
            int pw;
            pw = (i < 1500) ? 70 : 30;
            step($urandom_range(99) < pw, $urandom_range(99) < 50,
                 DW'($urandom), $urandom_range(99) < 5);
        end
        read_n(TOTAL - 4000 > 0 ? 2 : 2);
        while (mq.size() != 0) step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_banked.md
Name: fifo_banked

Overview:
Parametrised successor to the two-bank 4096-entry FIFO. It is one logical FIFO of NUM_BANKS*BANK_DEPTH words, physically split into NUM_BANKS equal banks. Writes fill the banks in order and wrap around; reads drain in the same order. It adds per-bank and aggregate flags, programmable almost-full/almost-empty flags, an occupancy count, sticky overflow/underflow errors and a registered read port with a valid strobe.

Parameters:
DATA_WIDTH, 16, word width
BANK_DEPTH, 2048, words per bank; power of 2, >=2
NUM_BANKS, 2, bank count; power of 2, >=1
AFULL_THRESH, TOTAL-16, almost_full asserted when count >= this
AEMPTY_THRESH, 16, almost_empty asserted when count <= this
(derived) TOTAL = NUM_BANKS*BANK_DEPTH; PTR_W = clog2(TOTAL); CNT_W = PTR_W+1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
wr  in  1  write request
data_in  in  DATA_WIDTH  write data
rd  in  1  read request
data_out  out  DATA_WIDTH  read data, registered
data_valid  out  1  one-cycle strobe: data_out updated this cycle
empty  out  1  count==0
full  out  1  count==TOTAL
almost_empty  out  1  count<=AEMPTY_THRESH
almost_full  out  1  count>=AFULL_THRESH
bank_empty  out  NUM_BANKS  bit b: bank b holds 0 words
bank_full  out  NUM_BANKS  bit b: bank b holds BANK_DEPTH words
count  out  CNT_W  total occupancy, 0..TOTAL
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst=0, asynchronous) values: pointers 0, count 0, per-bank counts 0, data_out 0, data_valid 0, empty 1, full 0, almost_empty 1, almost_full 0, bank_empty all 1, bank_full all 0, overflow 0, underflow 0. Memory contents are not reset.
- Reset mid-operation discards all stored data. The first read after reset returns the first word written after reset.
- Pointers wr_ptr and rd_ptr are PTR_W bits wide and wrap modulo TOTAL. Bank index = ptr[PTR_W-1 -: log2(NUM_BANKS)]. Bank address = the low log2(BANK_DEPTH) bits.
- Write accept: wr && !full. mem[wr_ptr] <= data_in and wr_ptr++ on the same edge.
- Read accept: rd && !empty, where empty is evaluated before this edge. There is no fall-through: a read on an empty FIFO is rejected even if a write occurs in the same cycle.
- Read latency is 1 cycle. On an accepted read, data_out <= mem[rd_ptr], rd_ptr++ and data_valid=1 in the following cycle. Otherwise data_valid=0 and data_out holds its last value.
- count update: +1 on write only, -1 on read only, unchanged when both are accepted or neither is.
- When full with rd&&wr: the read is accepted, the write is rejected and overflow is set.
- When empty with rd&&wr: the write is accepted, the read is rejected and underflow is set.
- Per-bank counts update by the same rules, using the bank index of the pointer involved. A simultaneous read and write in the same bank leaves that bank's count unchanged.
- bank_empty, bank_full, empty, full, almost_empty and almost_full are combinational from registered counts, so they reflect the state after the last edge.
- Errors: overflow is set when wr && full; underflow is set when rd && empty. clr_err clears both, but a same-cycle set takes priority over the clear.
- Wrap-around: after the last address of bank NUM_BANKS-1, writing continues at bank 0 address 0, with data order preserved.

Decomposition:
- Package fifo_banked_pkg:
  - derived-width functions (PTR_W, CNT_W, bank index width)
  - default threshold constants
  - bank/address split helper function
- Sub-module fifo_bank_ram: a one-bank simple dual-port RAM (DATA_WIDTH x BANK_DEPTH) with a registered read. It is instantiated NUM_BANKS times via generate; write enable is decoded from the bank index. The top level muxes the read data by the bank index registered at the read edge.
- Top level holds the pointers, counters, flags and error logic.

Test Plan:
- Fill: with defaults, write 0..4095 on consecutive cycles, no reads. Checks:
  - bank_full=2'b01 after 2048 writes
  - full=1, count=4096 and bank_full=2'b11 after 4096 writes
  - almost_full first high at count 4080
- Drain: after the fill, read 4096 times. data_out must be 0..4095 in order, each with data_valid one cycle after its rd. Afterwards empty=1, almost_empty=1 from count 16 down, and bank_empty returns to 2'b11.
- Overflow/underflow: wr while full leaves count 4096 and sets overflow. rd while empty sets underflow with data_valid=0. clr_err clears both, and a clr_err coinciding with a new error leaves the error flag at 1.
- Simultaneous: at count 100, rd&&wr for 50 cycles keeps count=100 with output order intact. With full and rd&&wr, count becomes 4095 and overflow=1. With empty and rd&&wr, count becomes 1 and underflow=1.
- Wrap: write 3000, read 3000, then write 2000 (bank1 to bank0 crossing at the 1096th). Read-back gives exactly the 2000 values in order; bank_empty=2'b00 mid-sequence.
- Reset mid-operation: at count 1234, pulse rst low for 5 ns, asynchronously between clock edges. Outputs take their reset values immediately; the next write/read pair returns the new data with count 1 then 0.
